// File: rtl/reg_fetch_mp.sv
`default_nettype none
// ============================================================================
//  Module      : reg_fetch_mp
//  Description : Register-fetch stage between the scheduler and execute.
//                Holds the integer architectural register file (NUM_WB write
//                ports, NUM_RD read ports).
//                Same-cycle write-back data is forwarded into the captured
//                operands. Held operands are refreshed from write-back while
//                the stage is stalled. Register x0 is hardwired to zero.
//                Latency is one cycle, and every output comes from a flop.
//  Ports       : i_clk, i_rst        clock, synchronous active-high reset
//                i_flush, i_stall    kill / hold the output register
//                i_valid, i_payload  incoming instruction and opaque payload
//                i_rs_valid, i_rs_idx  per-port read request and index
//                i_wb_valid, i_wb_idx, i_wb_data  write-back ports
//                o_valid, o_payload, o_rs_valid, o_rs_data  captured stage
//  Revision    : 1.0  initial release
// ============================================================================
module reg_fetch_mp #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WB    = 2,
    parameter int PAYLOAD_W = 64,
    parameter int IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_flush,
    input  logic                      i_stall,
    input  logic                      i_valid,
    input  logic [PAYLOAD_W-1:0]      i_payload,
    input  logic [NUM_RD-1:0]         i_rs_valid,
    input  logic [NUM_RD*IDX_W-1:0]   i_rs_idx,
    input  logic [NUM_WB-1:0]         i_wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]   i_wb_idx,
    input  logic [NUM_WB*XLEN-1:0]    i_wb_data,
    output logic                      o_valid,
    output logic [PAYLOAD_W-1:0]      o_payload,
    output logic [NUM_RD-1:0]         o_rs_valid,
    output logic [NUM_RD*XLEN-1:0]    o_rs_data
);

    localparam logic [IDX_W-1:0] c_ZERO_IDX = '0;

    // Architectural register file; entry 0 is never written.
    logic [XLEN-1:0]      r_regs     [NUM_REGS];

    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [NUM_RD-1:0]    r_rs_valid;
    logic [XLEN-1:0]      r_rs_data  [NUM_RD];
    logic [IDX_W-1:0]     r_held_idx [NUM_RD];

    // Unpacked views of the flat port buses.
    logic [IDX_W-1:0]     w_rd_idx   [NUM_RD];
    logic [IDX_W-1:0]     w_wb_idx   [NUM_WB];
    logic [XLEN-1:0]      w_wb_data  [NUM_WB];

    logic [XLEN-1:0]      w_eff      [NUM_RD];
    logic [NUM_RD-1:0]    w_hold_hit;
    logic [XLEN-1:0]      w_hold_data[NUM_RD];

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_unpack
            assign w_rd_idx[p]                 = i_rs_idx[p*IDX_W +: IDX_W];
            assign o_rs_data[p*XLEN +: XLEN]   = r_rs_data[p];
        end
        for (genvar w = 0; w < NUM_WB; w++) begin : g_wb_unpack
            assign w_wb_idx[w]  = i_wb_idx[w*IDX_W +: IDX_W];
            assign w_wb_data[w] = i_wb_data[w*XLEN +: XLEN];
        end
    endgenerate

    // Effective read value and stall-refresh selection. Ports are scanned in
    // ascending order so the highest-numbered matching write-back wins,
    // matching the register-file write priority below.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            w_eff[p]       = r_regs[w_rd_idx[p]];
            w_hold_hit[p]  = 1'b0;
            w_hold_data[p] = '0;
            for (int w = 0; w < NUM_WB; w++) begin
                if (i_wb_valid[w] && (w_wb_idx[w] == w_rd_idx[p])) begin
                    w_eff[p] = w_wb_data[w];
                end
                if (i_wb_valid[w] && r_rs_valid[p] &&
                    (r_held_idx[p] != c_ZERO_IDX) &&
                    (w_wb_idx[w] == r_held_idx[p])) begin
                    w_hold_hit[p]  = 1'b1;
                    w_hold_data[p] = w_wb_data[w];
                end
            end
            if (w_rd_idx[p] == c_ZERO_IDX) begin
                w_eff[p] = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_valid    <= 1'b0;
            r_payload  <= '0;
            r_rs_valid <= '0;
            for (int p = 0; p < NUM_RD; p++) begin
                r_rs_data[p]  <= '0;
                r_held_idx[p] <= '0;
            end
        end else begin
            // Later ports overwrite earlier ones on an index collision.
            for (int w = 0; w < NUM_WB; w++) begin
                if (i_wb_valid[w] && (w_wb_idx[w] != c_ZERO_IDX)) begin
                    r_regs[w_wb_idx[w]] <= w_wb_data[w];
                end
            end

            if (i_flush) begin
                r_valid    <= 1'b0;
                r_payload  <= '0;
                r_rs_valid <= '0;
                for (int p = 0; p < NUM_RD; p++) begin
                    r_rs_data[p] <= '0;
                end
            end else if (!i_stall) begin
                r_valid    <= i_valid;
                r_payload  <= i_payload;
                r_rs_valid <= i_rs_valid;
                for (int p = 0; p < NUM_RD; p++) begin
                    r_rs_data[p]  <= i_rs_valid[p] ? w_eff[p] : '0;
                    r_held_idx[p] <= w_rd_idx[p];
                end
            end else begin
                // Stalled: keep held operands current with write-back.
                for (int p = 0; p < NUM_RD; p++) begin
                    if (w_hold_hit[p]) begin
                        r_rs_data[p] <= w_hold_data[p];
                    end
                end
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_payload  = r_payload;
    assign o_rs_valid = r_rs_valid;

endmodule
`default_nettype wire

// File: tb/tb_reg_fetch_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_fetch_mp
//  Description : Self-checking bench for reg_fetch_mp with a behavioural
//                model of the architectural state plus literal checkpoints.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_fetch_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        stall;
    logic        valid;
    logic [63:0] payload;
    logic [1:0]  rs_valid;
    logic [9:0]  rs_idx;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_idx;
    logic [63:0] wb_data;
    logic        o_valid;
    logic [63:0] o_payload;
    logic [1:0]  o_rs_valid;
    logic [63:0] o_rs_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    reg_fetch_mp dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_flush    (flush),
        .i_stall    (stall),
        .i_valid    (valid),
        .i_payload  (payload),
        .i_rs_valid (rs_valid),
        .i_rs_idx   (rs_idx),
        .i_wb_valid (wb_valid),
        .i_wb_idx   (wb_idx),
        .i_wb_data  (wb_data),
        .o_valid    (o_valid),
        .o_payload  (o_payload),
        .o_rs_valid (o_rs_valid),
        .o_rs_data  (o_rs_data)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    bit          m_live = 0;
    logic        m_valid;
    logic [63:0] m_payload;
    logic [1:0]  m_rsv;
    logic [31:0] m_data [2];
    logic [4:0]  m_idx  [2];
    // Per-cycle write-back result table: does register r get written, and with what.
    bit          wb_hit [32];
    logic [31:0] wb_val [32];

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 32'h0;
            m_valid = 1'b0; m_payload = 64'h0; m_rsv = 2'b0;
            m_data[0] = 32'h0; m_data[1] = 32'h0;
            m_idx[0] = 5'd0; m_idx[1] = 5'd0;
            m_live = 1;
        end else begin
            foreach (wb_hit[i]) begin wb_hit[i] = 0; wb_val[i] = 32'h0; end
            for (int w = 0; w < 2; w++) begin
                if (wb_valid[w] && wb_idx[w*5 +: 5] != 5'd0) begin
                    wb_hit[wb_idx[w*5 +: 5]] = 1;
                    wb_val[wb_idx[w*5 +: 5]] = wb_data[w*32 +: 32];
                end
            end
            if (flush) begin
                m_valid = 1'b0; m_payload = 64'h0; m_rsv = 2'b0;
                m_data[0] = 32'h0; m_data[1] = 32'h0;
            end else if (!stall) begin
                m_valid = valid; m_payload = payload; m_rsv = rs_valid;
                for (int p = 0; p < 2; p++) begin
                    m_idx[p] = rs_idx[p*5 +: 5];
                    if (!rs_valid[p])           m_data[p] = 32'h0;
                    else if (m_idx[p] == 5'd0)  m_data[p] = 32'h0;
                    else if (wb_hit[m_idx[p]])  m_data[p] = wb_val[m_idx[p]];
                    else                        m_data[p] = m_regs[m_idx[p]];
                end
            end else begin
                for (int p = 0; p < 2; p++)
                    if (m_rsv[p] && wb_hit[m_idx[p]]) m_data[p] = wb_val[m_idx[p]];
            end
            foreach (wb_hit[i]) if (wb_hit[i]) m_regs[i] = wb_val[i];
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_live) begin
            chk("cmp_valid",    {63'h0, o_valid},    {63'h0, m_valid});
            chk("cmp_payload",  o_payload,           m_payload);
            chk("cmp_rs_valid", {62'h0, o_rs_valid}, {62'h0, m_rsv});
            chk("cmp_rs_data",  o_rs_data,           {m_data[1], m_data[0]});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        flush = 0; stall = 0; valid = 0; payload = 64'h0;
        rs_valid = 2'b0; rs_idx = 10'h0; wb_valid = 2'b0; wb_idx = 10'h0; wb_data = 64'h0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic rd(input int p, input logic [4:0] idx);
        rs_valid[p] = 1'b1; rs_idx[p*5 +: 5] = idx;
    endtask

    task automatic wb(input int w, input logic [4:0] idx, input logic [31:0] d);
        wb_valid[w] = 1'b1; wb_idx[w*5 +: 5] = idx; wb_data[w*32 +: 32] = d;
    endtask

    initial begin
        rst = 1; idle();
        // 1: reset with a pending write of x5
        wb(0, 5'd5, 32'h7);
        tick();
        chk("rst_valid", {63'h0, o_valid}, 64'h0);
        chk("rst_data",  o_rs_data, 64'h0);
        chk("rst_payload", o_payload, 64'h0);
        rst = 0; idle();
        valid = 1; rd(0, 5'd5); tick();
        chk("rst_x5_dropped", o_rs_data, 64'h0);

        // 2: plain read
        idle(); wb(0, 5'd3, 32'hDEADBEEF); tick();
        idle(); tick();
        valid = 1; payload = 64'hA5A5_0000_0000_0002; rd(0, 5'd3); rd(1, 5'd0); tick();
        chk("plain_data",  o_rs_data, {32'h0, 32'hDEADBEEF});
        chk("plain_valid", {63'h0, o_valid}, 64'h1);

        // 3: bypass with a two-port collision, highest port wins
        idle(); valid = 1; rd(0, 5'd7); wb(0, 5'd7, 32'h11); wb(1, 5'd7, 32'h22); tick();
        chk("bypass_data", {32'h0, o_rs_data[31:0]}, 64'h22);
        idle(); valid = 1; rd(0, 5'd7); tick();
        chk("bypass_later", {32'h0, o_rs_data[31:0]}, 64'h22);

        // 4: stall refresh of a held operand
        idle(); wb(0, 5'd9, 32'h1); tick();
        idle(); valid = 1; payload = 64'hCAFE_0000_0000_0004; rd(1, 5'd9); tick();
        chk("stall_cap", {32'h0, o_rs_data[63:32]}, 64'h1);
        stall = 1; valid = 0; payload = 64'h0; rs_valid = 2'b0; tick();
        chk("stall_c1", {32'h0, o_rs_data[63:32]}, 64'h1);
        wb(1, 5'd9, 32'h55); tick();
        chk("stall_c2", {32'h0, o_rs_data[63:32]}, 64'h55);
        wb_valid = 2'b0; tick();
        chk("stall_c3", {32'h0, o_rs_data[63:32]}, 64'h55);
        chk("stall_payload", o_payload, 64'hCAFE_0000_0000_0004);

        // 5: flush during stall with a concurrent write
        flush = 1; wb(0, 5'd4, 32'h9); tick();
        chk("flush_valid", {63'h0, o_valid}, 64'h0);
        chk("flush_data",  o_rs_data, 64'h0);
        chk("flush_payload", o_payload, 64'h0);
        idle(); valid = 1; rd(0, 5'd4); tick();
        chk("flush_x4", {32'h0, o_rs_data[31:0]}, 64'h9);

        // 6: x0 writes are dropped, including the bypass path
        idle(); wb(0, 5'd0, 32'hFF); tick();
        idle(); valid = 1; rd(0, 5'd0); rd(1, 5'd0); tick();
        chk("x0_read", o_rs_data, 64'h0);
        idle(); valid = 1; rd(0, 5'd0); wb(1, 5'd0, 32'hFF); tick();
        chk("x0_bypass", o_rs_data, 64'h0);

        // stall with an unrequested port: a WB hit on its index must not load it
        idle(); valid = 1; rd(0, 5'd3); rs_idx[9:5] = 5'd12; tick();
        stall = 1; rs_valid = 2'b0; wb(0, 5'd12, 32'h777); tick();
        chk("stall_unreq", {32'h0, o_rs_data[63:32]}, 64'h0);

        // 7: mid-operation reset while stalled with a valid instruction
        idle(); valid = 1; payload = 64'h7; rd(0, 5'd3); tick();
        stall = 1; tick();
        rst = 1; tick();
        chk("mid_rst_valid", {63'h0, o_valid}, 64'h0);
        rst = 0; idle(); stall = 1; tick();
        chk("mid_rst_hold", {63'h0, o_valid}, 64'h0);
        idle(); valid = 1; rd(0, 5'd3); tick();
        chk("mid_rst_x3", {32'h0, o_rs_data[31:0]}, 64'h0);

        // Mixed traffic over a small index range to force collisions.
        for (int i = 0; i < 300; i++) begin
            idle();
            flush    = ($urandom_range(0, 9) == 0);
            stall    = ($urandom_range(0, 2) == 0);
            valid    = $urandom_range(0, 1);
            payload  = {$urandom, $urandom};
            rs_valid = 2'($urandom_range(0, 3));
            rs_idx   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wb_valid = 2'($urandom_range(0, 3));
            wb_idx   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wb_data  = {$urandom, $urandom};
            tick();
        end

        idle(); tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
